bk_slot_sequencer: RTL
======================

Name: bk_slot_sequencer

Overview:
- Parametrised save-state / backup-RAM sector sequencer between the core's backup RAM port and hps_io's sd_lba/sd_rd/sd_wr/sd_ack handshake.
- Streams SECTORS consecutive 512-byte sectors per slot to or from the mounted save image. Supports any slot count and sector count.
- Adds an ack timeout with error reporting and a dirty-tracking autosave mode.
- Drives the core hold-in-reset (bk_loading) and the user LED (bk_busy).

Parameters:
- SECTORS, 64, sectors per slot (1..65536).
- SLOTS, 4, number of save slots (1..256).
- SLOT_W, 2, width of the slot input; requires 2^SLOT_W >= SLOTS.
- BASE_LBA, 0, LBA of slot 0, sector 0.
- TIMEOUT, 1048576, clk_sys cycles allowed for each ack edge.
- AUTOSAVE_DELAY, 4194304, quiet cycles after the last dirty pulse before an autosave starts.

Ports:
- clk_sys  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- bk_ena  in  1  save image mounted and writable; requests are ignored while low.
- load_req  in  1  level from the OSD; its rising edge starts a load.
- save_req  in  1  level from the OSD; its rising edge starts a save.
- slot  in  SLOT_W  target slot, sampled at start.
- autosave_en  in  1  enables autosave.
- dirty  in  1  single-cycle pulse on each backup RAM write by the core.
- sd_ack  in  1  hps_io transfer acknowledge.
- sd_lba  out  32  current sector address.
- sd_rd  out  1  sector read request.
- sd_wr  out  1  sector write request.
- sector_idx  out  16  sector index within the slot; the backup RAM address high bits.
- bk_loading  out  1  high for the whole of a load.
- bk_busy  out  1  high while any transfer is active.
- bk_done  out  1  one-cycle pulse on successful completion.
- bk_err  out  1  sticky error flag.

Behaviour:
- Reset values: sd_lba=0, sd_rd=0, sd_wr=0, sector_idx=0, bk_loading=0, bk_busy=0, bk_done=0, bk_err=0. Dirty flag cleared, quiet counter 0, state IDLE. Edge detectors load the current input levels, so a level held high through reset does not start a transfer.
- Edge detection uses registered previous levels. An edge only counts when it coincides with bk_ena=1.
- States: IDLE, ISSUE, WAIT_HI, WAIT_LO, ERROR.
- IDLE -> ISSUE on a valid request.
  - Load edge beats save edge in the same cycle; beats autosave.
  - Manual save beats autosave.
  - Edges arriving outside IDLE are discarded, not queued.
- Start actions:
  - If slot >= SLOTS: set bk_err, stay in IDLE.
  - Otherwise latch the slot, clear bk_err, sector_idx=0, bk_busy=1, bk_loading = (op is load).
  - Save (manual or auto) clears the dirty flag at start.
- ISSUE: sd_lba = BASE_LBA + slot*SECTORS + sector_idx, 32-bit and registered. Assert sd_rd (load) or sd_wr (save) in the same cycle, then go to WAIT_HI.
- WAIT_HI: on sd_ack=1, deassert sd_rd and sd_wr in that same cycle, then go to WAIT_LO.
- WAIT_LO: on sd_ack=0:
  - If sector_idx == SECTORS-1: go to IDLE, bk_busy=0, bk_loading=0, one-cycle bk_done=1. A completed load also clears the dirty flag.
  - Otherwise increment sector_idx and go to ISSUE.
- Timeout: a 32-bit counter clears on entry to WAIT_HI and to WAIT_LO. Reaching TIMEOUT in either state goes to ERROR.
- ERROR (one cycle): sd_rd=0, sd_wr=0, bk_err=1, bk_busy=0, bk_loading=0, then IDLE. sector_idx holds its value for debug.
- Autosave: a dirty pulse sets the dirty flag and clears the quiet counter. In IDLE, with autosave_en=1, bk_ena=1 and the flag set, the counter increments. When it reaches AUTOSAVE_DELAY, a save starts on the last latched slot (0 after reset). The counter saturates and is not counted outside IDLE.
- Dirty pulses during a save set the flag again, so a further autosave follows.
- sd_ack rising in IDLE (stale ack after reset) is ignored.
- Reset mid-transfer takes effect next cycle: all outputs return to reset values and no further requests are issued.
- Throughput: one sector costs 1 ISSUE cycle plus the ack round trip. Back-to-back sectors need no idle gap beyond ISSUE.

Test Plan:
- SECTORS=64, SLOTS=4, BASE_LBA=0, slot=2, save_req rises, ack model 5 cycles high / 3 cycles low -> sd_wr pulses 64 times, sd_lba 128..191, bk_busy high throughout, one bk_done, bk_loading stays 0.
- load_req and save_req rise in the same cycle, slot=1 -> load only: sd_rd pulses, bk_loading=1 until after LBA 127, sd_wr never asserted.
- SLOTS=3, slot=3, save_req rises -> bk_err=1, no sd_wr, bk_busy stays 0. A subsequent valid load clears bk_err.
- TIMEOUT=100, ack never rises -> after 100 cycles in WAIT_HI, sd_rd=0, bk_err=1, bk_busy=0, no bk_done.
- AUTOSAVE_DELAY=1000, autosave_en=1, dirty pulses at t=0 and t=500 -> save starts at t≈1500. No save if autosave_en=0 or bk_ena=0.
- reset asserted mid-load at sector 10 -> next cycle sd_rd=0, bk_loading=0, state IDLE. A stale ack then toggles with no new request. A fresh load restarts at sector_idx 0.

Source files
------------

// File: rtl/bk_slot_sequencer_if.sv
// ============================================================================
// Module   : bk_slot_sequencer_if
// Brief    : hps_io sector handshake bundle (sd_lba/sd_rd/sd_wr/sd_ack).
// Revision : 1.0
// ============================================================================
`default_nettype none

interface bk_slot_sequencer_if;
  logic [31:0] sd_lba;
  logic        sd_rd;
  logic        sd_wr;
  logic        sd_ack;

  modport master (output sd_lba, output sd_rd, output sd_wr, input sd_ack);
  modport slave  (input sd_lba, input sd_rd, input sd_wr, output sd_ack);
endinterface

`default_nettype wire

// File: rtl/bk_slot_sequencer.sv
// ============================================================================
// Module   : bk_slot_sequencer
// Brief    : Backup-RAM slot load/save sector sequencer with ack timeout and
//            dirty-tracking autosave.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bk_slot_sequencer #(
  parameter int SECTORS        = 64,
  parameter int SLOTS          = 4,
  parameter int SLOT_W         = 2,
  parameter int BASE_LBA       = 0,
  parameter int TIMEOUT        = 1048576,
  parameter int AUTOSAVE_DELAY = 4194304
) (
  input  wire logic              clk_sys,
  input  wire logic              reset,
  input  wire logic              bk_ena,
  input  wire logic              load_req,
  input  wire logic              save_req,
  input  wire logic [SLOT_W-1:0] slot,
  input  wire logic              autosave_en,
  input  wire logic              dirty,
  bk_slot_sequencer_if.master    sd,
  output logic [15:0]            sector_idx,
  output logic                   bk_loading,
  output logic                   bk_busy,
  output logic                   bk_done,
  output logic                   bk_err
);

  localparam logic [15:0] c_last_idx     = 16'(SECTORS - 1);
  localparam logic [31:0] c_timeout_last = 32'(TIMEOUT - 1);
  localparam logic [31:0] c_autosave     = 32'(AUTOSAVE_DELAY);
  localparam logic [31:0] c_base         = 32'(BASE_LBA);
  localparam logic [31:0] c_sectors      = 32'(SECTORS);
  localparam logic [31:0] c_slots        = 32'(SLOTS);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT_HI = 3'd2,
    ST_WAIT_LO = 3'd3,
    ST_ERROR   = 3'd4
  } state_t;

  state_t            r_state;
  logic              r_load_prev;
  logic              r_save_prev;
  logic              r_dirty;
  logic              r_is_load;
  logic [31:0]       r_quiet;
  logic [31:0]       r_timer;
  logic [SLOT_W-1:0] r_slot;

  logic              w_load_edge;
  logic              w_save_edge;
  logic              w_auto;
  logic              w_start;
  logic [SLOT_W-1:0] w_start_slot;
  logic              w_slot_ok;
  logic              w_save_start;
  logic              w_load_done;
  logic              w_quiet_run;

  assign w_load_edge  = load_req & ~r_load_prev & bk_ena;
  assign w_save_edge  = save_req & ~r_save_prev & bk_ena;
  assign w_auto       = autosave_en & bk_ena & r_dirty & (r_quiet == c_autosave);
  assign w_start      = (r_state == ST_IDLE) & (w_load_edge | w_save_edge | w_auto);
  // Manual requests use the live slot input; autosave reuses the last latched slot.
  assign w_start_slot = (w_load_edge | w_save_edge) ? slot : r_slot;
  assign w_slot_ok    = 32'(w_start_slot) < c_slots;
  assign w_save_start = w_start & ~w_load_edge & w_slot_ok;
  assign w_load_done  = (r_state == ST_WAIT_LO) & ~sd.sd_ack & r_is_load &
                        (sector_idx == c_last_idx);
  assign w_quiet_run  = (r_state == ST_IDLE) & autosave_en & bk_ena & r_dirty &
                        (r_quiet != c_autosave);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_load_prev <= load_req;
      r_save_prev <= save_req;
      r_dirty     <= 1'b0;
      r_is_load   <= 1'b0;
      r_quiet     <= '0;
      r_timer     <= '0;
      r_slot      <= '0;
      sd.sd_lba   <= '0;
      sd.sd_rd    <= 1'b0;
      sd.sd_wr    <= 1'b0;
      sector_idx  <= '0;
      bk_loading  <= 1'b0;
      bk_busy     <= 1'b0;
      bk_done     <= 1'b0;
      bk_err      <= 1'b0;
    end else begin
      r_load_prev <= load_req;
      r_save_prev <= save_req;
      bk_done     <= 1'b0;

      // A write by the core always wins, so writes during a save re-arm autosave.
      if (dirty) begin
        r_dirty <= 1'b1;
        r_quiet <= '0;
      end else if (w_save_start || w_load_done) begin
        r_dirty <= 1'b0;
        r_quiet <= '0;
      end else if (w_quiet_run) begin
        r_quiet <= r_quiet + 32'd1;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            if (!w_slot_ok) begin
              bk_err <= 1'b1;
            end else begin
              r_slot     <= w_start_slot;
              r_is_load  <= w_load_edge;
              bk_err     <= 1'b0;
              sector_idx <= '0;
              bk_busy    <= 1'b1;
              bk_loading <= w_load_edge;
              r_state    <= ST_ISSUE;
            end
          end
        end

        ST_ISSUE: begin
          sd.sd_lba <= c_base + 32'(r_slot) * c_sectors + 32'(sector_idx);
          sd.sd_rd  <= r_is_load;
          sd.sd_wr  <= ~r_is_load;
          r_timer   <= '0;
          r_state   <= ST_WAIT_HI;
        end

        ST_WAIT_HI: begin
          if (sd.sd_ack) begin
            sd.sd_rd <= 1'b0;
            sd.sd_wr <= 1'b0;
            r_timer  <= '0;
            r_state  <= ST_WAIT_LO;
          end else if (r_timer == c_timeout_last) begin
            sd.sd_rd   <= 1'b0;
            sd.sd_wr   <= 1'b0;
            bk_err     <= 1'b1;
            bk_busy    <= 1'b0;
            bk_loading <= 1'b0;
            r_state    <= ST_ERROR;
          end else begin
            r_timer <= r_timer + 32'd1;
          end
        end

        ST_WAIT_LO: begin
          if (!sd.sd_ack) begin
            if (sector_idx == c_last_idx) begin
              bk_busy    <= 1'b0;
              bk_loading <= 1'b0;
              bk_done    <= 1'b1;
              r_state    <= ST_IDLE;
            end else begin
              sector_idx <= sector_idx + 16'd1;
              r_state    <= ST_ISSUE;
            end
          end else if (r_timer == c_timeout_last) begin
            sd.sd_rd   <= 1'b0;
            sd.sd_wr   <= 1'b0;
            bk_err     <= 1'b1;
            bk_busy    <= 1'b0;
            bk_loading <= 1'b0;
            r_state    <= ST_ERROR;
          end else begin
            r_timer <= r_timer + 32'd1;
          end
        end

        ST_ERROR: begin
          // sector_idx is left untouched so the failing sector stays visible.
          sd.sd_rd   <= 1'b0;
          sd.sd_wr   <= 1'b0;
          bk_err     <= 1'b1;
          bk_busy    <= 1'b0;
          bk_loading <= 1'b0;
          r_state    <= ST_IDLE;
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
